// File: rtl/ext_intr_ctrl.sv
// Machine-level external interrupt controller: synchronised edge-triggered sources,
// pending/enable state, claim on trap and retire on mret. Optional timer source under MTIMER_EN.
module ext_intr_ctrl #(
  parameter int unsigned NSRC        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            trap_taken,
  input  logic            mret_m,
  input  logic [2:0]      reg_addr,
  input  logic            reg_we,
  input  logic [31:0]     reg_wdata,
  output logic [31:0]     reg_rdata,
  output logic            intr_excep,
  output logic [3:0]      claim_id
);

`ifdef MTIMER_EN
  localparam int unsigned NREQ = NSRC + 1;
`else
  localparam int unsigned NREQ = NSRC;
`endif

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] clr_mask;
  logic [NREQ-1:0] enable_q;
  logic [NREQ-1:0] req;
  logic [3:0]      win_id;
  logic [3:0]      claim_d;
  logic            intr_d;
  logic            claim_fire;
  logic            unused_wdata;

  assign unused_wdata = ^reg_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q    <= sync_q[SYNC_STAGES-1];
      // A fresh edge on the claimed source survives its own clear
      pending_q <= (pending_q & ~clr_mask) | rise;
      if (reg_we && reg_addr == 3'd1) enable_q <= reg_wdata[NREQ-1:0];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

`ifdef MTIMER_EN
  logic [31:0] mtime_q;
  logic [31:0] mtimecmp_q;
  logic        timer_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      if (reg_we && reg_addr == 3'd4) mtime_q <= reg_wdata;
      else                            mtime_q <= mtime_q + 32'd1;
      if (reg_we && reg_addr == 3'd3) mtimecmp_q <= reg_wdata;
    end
  end

  assign timer_lvl = (mtime_q >= mtimecmp_q);
  assign req       = {timer_lvl, pending_q} & enable_q;
`else
  assign req = pending_q & enable_q;
`endif

  // Lowest index wins, so scan from the top and let lower hits overwrite
  always_comb begin
    win_id = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (req[i-1]) win_id = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      intr_excep <= 1'b0;
      claim_id   <= '0;
    end else begin
      state_q    <= state_d;
      intr_excep <= intr_d;
      claim_id   <= claim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = REQ;
      REQ: begin
        if (trap_taken)  state_d = SERVICE;
        else if (~|req)  state_d = IDLE;
      end
      SERVICE: if (mret_m) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    intr_d     = (state_d == REQ);
    claim_fire = (state_q == REQ) && trap_taken;
    claim_d    = claim_id;
    if (claim_fire)                         claim_d = win_id;
    else if (state_q == SERVICE && mret_m)  claim_d = '0;
    clr_mask = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      clr_mask[i] = claim_fire && (win_id == 4'(i + 1));
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0: begin
        reg_rdata[NSRC-1:0] = pending_q;
`ifdef MTIMER_EN
        reg_rdata[NSRC] = timer_lvl;
`endif
      end
      3'd1: reg_rdata[NREQ-1:0] = enable_q;
      3'd2: reg_rdata[3:0]      = claim_id;
`ifdef MTIMER_EN
      3'd3: reg_rdata = mtimecmp_q;
      3'd4: reg_rdata = mtime_q;
`endif
      default: reg_rdata = '0;
    endcase
  end

endmodule
